// File: rtl/debounce_arbiter.sv
// debounce_arbiter
//   Four push buttons share a single debounce timer. Each raw pin goes through
//   a two-flop synchroniser. One pressed button at a time is granted the timer,
//   chosen in round-robin order. A debounced press emits a one-cycle click and
//   updates an 8-bit LED counter: btn0 adds 1, btn1 subtracts 1, btn2 clears
//   the counter and btn3 adds 16. The counter wraps modulo 256.
//
// Handshake: none. The inputs are free-running button levels, and click is a
//   single-cycle strobe with no back-pressure.
//
// Ports
//   clk      in   1  system clock; all logic updates on the rising edge
//   reset    in   1  synchronous, active-high
//   button   in   4  raw asynchronous button pins
//   click    out  4  one-hot, 1-cycle pulse for each debounced press
//   grant    out  2  index of the button that owns the timer (valid when busy)
//   busy     out  1  the timer is owned (FSM is not idle)
//   outleds  out  8  LED counter value
module debounce_arbiter #(
  parameter logic [31:0] DEBOUNCE_DELAY = 32'd500_000,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button,
  output logic [3:0] click,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] outleds
);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, RELEASE} state_t;

  localparam logic [31:0] LAST = DEBOUNCE_DELAY - 32'd1;

  state_t      state, state_nx;
  logic [3:0]  sync1, pressed;
  logic [31:0] timer, timer_nx;
  logic [1:0]  rr_ptr, rr_nx, grant_nx, pick;
  logic [7:0]  leds_nx;
  logic        any_pressed;

  // Round-robin pick. The loop scans from the farthest offset down to offset 0,
  // so the pressed button nearest rr_ptr is the one that wins.
  always_comb begin
    any_pressed = |pressed;
    pick        = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (pressed[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    rr_nx    = rr_ptr;
    grant_nx = grant;
    case (state)
      IDLE: begin
        if (any_pressed) begin
          grant_nx = pick;
          state_nx = COUNT;
          timer_nx = '0;
        end
      end
      COUNT: begin
        if (!pressed[grant]) begin
          // The press bounced away before it was stable, so abort with no click.
          state_nx = IDLE;
          rr_nx    = grant + 2'd1;
          timer_nx = '0;
        end else if (timer == LAST) begin
          state_nx = FIRE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end
      FIRE: begin
        state_nx = RELEASE;
        timer_nx = '0;
      end
      RELEASE: begin
        // The release must stay stable for the full delay. Any re-press
        // restarts the wait.
        if (pressed[grant]) begin
          timer_nx = '0;
        end else if (timer == LAST) begin
          state_nx = IDLE;
          rr_nx    = grant + 2'd1;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  always_comb begin
    leds_nx = outleds;
    if (state == FIRE) begin
      case (grant)
        2'd0:    leds_nx = outleds + 8'd1;
        2'd1:    leds_nx = outleds - 8'd1;
        2'd2:    leds_nx = 8'd0;
        default: leds_nx = outleds + 8'd16;
      endcase
    end
  end

  assign click = (state == FIRE) ? (4'b0001 << grant) : 4'b0000;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      pressed <= '0;
      state   <= IDLE;
      timer   <= '0;
      rr_ptr  <= '0;
      grant   <= '0;
      outleds <= '0;
    end else begin
      // The synchroniser stores the "pressed" polarity, so a value of 0
      // always means released.
      sync1   <= button ^ {4{ACTIVE_LOW}};
      pressed <= sync1;
      state   <= state_nx;
      timer   <= timer_nx;
      rr_ptr  <= rr_nx;
      grant   <= grant_nx;
      outleds <= leds_nx;
    end
  end

endmodule

// File: tb/tb_debounce_arbiter.sv
module tb_debounce_arbiter;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button = 4'hF;
  logic [3:0] click;
  logic [1:0] grant;
  logic       busy;
  logic [7:0] outleds;

  debounce_arbiter #(.DEBOUNCE_DELAY(32'(D)), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .button(button), .click(click),
    .grant(grant), .busy(busy), .outleds(outleds)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tot = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: the owner index (or -1 when free), the number of pressed
  // cycles it has held since the grant, whether it has fired yet, and the
  // run of released cycles seen after firing.
  logic [3:0] m_s1 = 4'h0, m_p = 4'h0;
  int         m_own = -1;
  int         m_held = 0, m_low = 0;
  bit         m_fired = 1'b0;
  logic [1:0] m_rr = 2'd0, m_gnt = 2'd0;
  logic [7:0] m_leds = 8'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 0; m_p = 0; m_own = -1; m_held = 0; m_low = 0; m_fired = 0;
      m_rr = 0; m_gnt = 0; m_leds = 0;
    end else begin
      if (m_own < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_own < 0 && m_p[(m_rr + k) % 4]) m_own = (m_rr + k) % 4;
        end
        if (m_own >= 0) begin
          m_gnt = 2'(m_own); m_held = 0; m_fired = 0; m_low = 0;
        end
      end else if (!m_fired) begin
        if (m_held == D) begin
          case (m_own)
            0: m_leds = m_leds + 8'd1;
            1: m_leds = m_leds - 8'd1;
            2: m_leds = 8'd0;
            default: m_leds = m_leds + 8'd16;
          endcase
          m_fired = 1; m_low = 0;
        end else if (!m_p[m_own]) begin
          m_rr = 2'((m_own + 1) % 4); m_own = -1;
        end else begin
          m_held++;
        end
      end else begin
        if (m_p[m_own]) m_low = 0;
        else if (m_low == D - 1) begin
          m_rr = 2'((m_own + 1) % 4); m_own = -1;
        end else m_low++;
      end
      m_p  = m_s1;
      m_s1 = ~button;
    end
  end

  function automatic logic [3:0] exp_click();
    if (m_own >= 0 && !m_fired && m_held == D) return 4'(1 << m_own);
    return 4'h0;
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [3:0] exp_q[$];
  int         ev_cyc[$];
  logic [3:0] ev_clk[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(m_own >= 0));
      chk("grant", 32'(grant), 32'(m_gnt));
      chk("click", 32'(click), 32'(exp_click()));
      chk("outleds", 32'(outleds), 32'(m_leds));
      if (exp_click() != 4'h0) exp_q.push_back(exp_click());
      if (click != 4'h0) begin
        ev_cyc.push_back(cyc);
        ev_clk.push_back(click);
        if (exp_q.size() == 0) chk("click_unexpected", 32'(click), 32'h0);
        else chk("click_order", 32'(click), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pressed(input logic [3:0] p);
    button = ~p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_pressed(4'h0);
    wait_cyc(3);
    reset = 1'b0;
    ev_cyc.delete();
    ev_clk.delete();
  endtask

  task automatic tap(input logic [3:0] p, input int hold, input int gap);
    set_pressed(p);
    wait_cyc(hold);
    set_pressed(4'h0);
    wait_cyc(gap);
  endtask

  // ---------------- stimulus ----------------
  int t0;
  initial begin
    wait_cyc(1);
    do_reset();
    chk("reset_leds", 32'(outleds), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // 1: a clean press gives one click, 11 cycles after the press
    t0 = cyc;
    tap(4'b0001, 20, 20);
    chk("t1_clicks", ev_cyc.size(), 1);
    if (ev_cyc.size() > 0) chk("t1_latency", ev_cyc[0] - t0, 11);
    chk("t1_leds", 32'(outleds), 32'd1);
    chk("t1_model_leds", 32'(m_leds), 32'd1);

    // 2: a bounce aborts the first count; the re-press fires once and wraps to 255
    do_reset();
    set_pressed(4'b0010); wait_cyc(5);
    set_pressed(4'b0000); wait_cyc(1);
    tap(4'b0010, 12, 20);
    chk("t2_clicks", ev_cyc.size(), 1);
    if (ev_clk.size() > 0) chk("t2_idx", 32'(ev_clk[0]), 32'h2);
    chk("t2_leds", 32'(outleds), 32'd255);

    // 3: a simultaneous press grants btn0 first, then btn1 after btn0 releases
    do_reset();
    set_pressed(4'b0011); wait_cyc(15);
    set_pressed(4'b0010); wait_cyc(30);
    set_pressed(4'b0000); wait_cyc(20);
    chk("t3_clicks", ev_cyc.size(), 2);
    if (ev_clk.size() > 1) begin
      chk("t3_first", 32'(ev_clk[0]), 32'h1);
      chk("t3_second", 32'(ev_clk[1]), 32'h2);
    end
    chk("t3_model_rr", 32'(m_rr), 32'd2);
    set_pressed(4'b1001); wait_cyc(4);
    chk("t3_rr_grant", 32'(grant), 32'd3);
    chk("t3_busy", 32'(busy), 32'd1);
    set_pressed(4'b0000); wait_cyc(20);

    // 4: wrap on the add-16 operation, then clear
    do_reset();
    repeat (6) tap(4'b0010, 12, 12);
    chk("t4_250", 32'(outleds), 32'd250);
    tap(4'b1000, 12, 12);
    chk("t4_plus16", 32'(outleds), 32'd10);
    chk("t4_model", 32'(m_leds), 32'd10);
    tap(4'b0100, 12, 12);
    chk("t4_clear", 32'(outleds), 32'd0);

    // 5: reset during COUNT (timer=5) aborts the press with no click
    do_reset();
    tap(4'b1000, 12, 12);
    chk("t5_pre_leds", 32'(outleds), 32'd16);
    ev_cyc.delete();
    set_pressed(4'b0001); wait_cyc(8);
    chk("t5_busy_before", 32'(busy), 32'd1);
    reset = 1'b1; wait_cyc(1);
    chk("t5_leds_zero", 32'(outleds), 32'd0);
    chk("t5_busy_zero", 32'(busy), 32'd0);
    reset = 1'b0; set_pressed(4'b0000); wait_cyc(20);
    chk("t5_no_click", ev_cyc.size(), 0);

    // 6: a long hold fires only once, and a short release does not re-arm
    do_reset();
    set_pressed(4'b0001); wait_cyc(100);
    chk("t6_single", ev_cyc.size(), 1);
    set_pressed(4'b0000); wait_cyc(5);
    set_pressed(4'b0001); wait_cyc(20);
    chk("t6_no_refire", ev_cyc.size(), 1);
    set_pressed(4'b0000); wait_cyc(12);
    tap(4'b0001, 20, 20);
    chk("t6_refire", ev_cyc.size(), 2);
    chk("t6_leds", 32'(outleds), 32'd2);

    // random segments, checked every cycle against the model
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; wait_cyc(1); reset = 1'b0;
      end
      set_pressed(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) set_pressed(4'h0);
      wait_cyc($urandom_range(1, 25));
    end
    set_pressed(4'h0);
    wait_cyc(30);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
